// File: rtl/discrete_filter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : discrete_filter_scheduler
// Purpose  : Shares one multiplier across NUM_CH one-pole RC filters. Each
//            audio_clk_en tick starts one pass over every channel.
// Option   : DISCRETE_FILTER_SCHED_SATURATE_EN (clamp instead of wrap)
// Revision : 1.0
// ============================================================================
module discrete_filter_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int SIGNAL_WIDTH = 16,
    parameter int COEF_WIDTH   = 16,
    localparam int C_ADDR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           I_RST,
    input  logic                           audio_clk_en,
    input  logic [NUM_CH*SIGNAL_WIDTH-1:0] in_flat,
    input  logic                           cfg_we,
    input  logic [C_ADDR_W-1:0]            cfg_addr,
    input  logic [COEF_WIDTH-1:0]          cfg_coef,
    input  logic                           cfg_hp,
    output logic [NUM_CH*SIGNAL_WIDTH-1:0] out_flat,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam int c_SW = SIGNAL_WIDTH;
    localparam int c_CW = COEF_WIDTH;
    localparam int c_PW = c_SW + c_CW + 2;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_MUL   = 3'd2;
    localparam logic [2:0] c_ST_WB    = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [C_ADDR_W-1:0] c_LAST_CH = C_ADDR_W'(NUM_CH - 1);

    logic [2:0]                r_state;
    logic [C_ADDR_W-1:0]       r_ch;
    logic signed [c_SW-1:0]    r_x   [NUM_CH];
    logic signed [c_SW-1:0]    r_y   [NUM_CH];
    logic signed [c_SW-1:0]    r_out [NUM_CH];
    logic [c_CW-1:0]           r_k_pend [NUM_CH];
    logic [c_CW-1:0]           r_k_act  [NUM_CH];
    logic [NUM_CH-1:0]         r_hp_pend;
    logic [NUM_CH-1:0]         r_hp_act;
    logic signed [c_SW:0]      r_diff;
    logic [c_CW-1:0]           r_k;
    logic signed [c_SW:0]      r_prod;
    logic                      r_done;
    logic                      r_overrun;

    logic signed [c_PW-1:0]    w_prod;
    logic signed [c_SW+1:0]    w_y_sum;
    logic signed [c_SW-1:0]    w_y_new;
    logic signed [c_SW+1:0]    w_hp_sum;
    logic signed [c_SW-1:0]    w_hp_out;
    logic                      w_unused_prod;
    logic                      w_cfg_ok;

    // k is a pure fraction, so the shifted product always fits in c_SW+1 bits
    assign w_prod        = c_PW'(r_diff) * c_PW'($signed({1'b0, r_k}));
    assign w_unused_prod = ^{w_prod[c_PW-1], w_prod[c_CW-1:0]};

    assign w_y_sum  = $signed({{2{r_y[r_ch][c_SW-1]}}, r_y[r_ch]}) + $signed({r_prod[c_SW], r_prod});
    assign w_hp_sum = $signed({{2{r_x[r_ch][c_SW-1]}}, r_x[r_ch]}) - $signed({{2{w_y_new[c_SW-1]}}, w_y_new});

`ifdef DISCRETE_FILTER_SCHED_SATURATE_EN
    localparam logic signed [c_SW+1:0] c_SAT_MAX = (c_SW+2)'((1 <<< (c_SW - 1)) - 1);
    localparam logic signed [c_SW+1:0] c_SAT_MIN = (c_SW+2)'(-(1 <<< (c_SW - 1)));

    function automatic logic signed [c_SW-1:0] f_sat(input logic signed [c_SW+1:0] v);
        if (v > c_SAT_MAX)      return c_SAT_MAX[c_SW-1:0];
        else if (v < c_SAT_MIN) return c_SAT_MIN[c_SW-1:0];
        else                    return v[c_SW-1:0];
    endfunction

    assign w_y_new  = f_sat(w_y_sum);
    assign w_hp_out = f_sat(w_hp_sum);
`else
    logic w_unused_wrap;
    assign w_y_new       = w_y_sum[c_SW-1:0];
    assign w_hp_out      = w_hp_sum[c_SW-1:0];
    assign w_unused_wrap = ^{w_y_sum[c_SW+1:c_SW], w_hp_sum[c_SW+1:c_SW]};
`endif

    assign w_cfg_ok = (32'(cfg_addr) < NUM_CH);

    // Pending bank accepts writes at any time; it only reaches the filters at a tick.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            for (int i = 0; i < NUM_CH; i++) r_k_pend[i] <= '0;
            r_hp_pend <= '0;
        end else if (cfg_we && w_cfg_ok) begin
            r_k_pend[cfg_addr]  <= cfg_coef;
            r_hp_pend[cfg_addr] <= cfg_hp;
        end
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state   <= c_ST_IDLE;
            r_ch      <= '0;
            r_diff    <= '0;
            r_k       <= '0;
            r_prod    <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_hp_act  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_out[i]   <= '0;
                r_k_act[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (audio_clk_en && (r_state != c_ST_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (audio_clk_en) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_x[i]     <= $signed(in_flat[i*c_SW +: c_SW]);
                            r_k_act[i] <= r_k_pend[i];
                        end
                        r_hp_act <= r_hp_pend;
                        r_ch     <= '0;
                        r_state  <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    r_diff  <= $signed({r_x[r_ch][c_SW-1], r_x[r_ch]}) - $signed({r_y[r_ch][c_SW-1], r_y[r_ch]});
                    r_k     <= r_k_act[r_ch];
                    r_state <= c_ST_MUL;
                end
                c_ST_MUL: begin
                    r_prod  <= w_prod[c_SW+c_CW:c_CW];
                    r_state <= c_ST_WB;
                end
                c_ST_WB: begin
                    r_y[r_ch]   <= w_y_new;
                    r_out[r_ch] <= r_hp_act[r_ch] ? w_hp_out : w_y_new;
                    if (r_ch == c_LAST_CH) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
        assign out_flat[gi*c_SW +: c_SW] = r_out[gi];
    end

    assign busy    = (r_state != c_ST_IDLE);
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_discrete_filter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_discrete_filter_scheduler
// Purpose  : Directed self-checking bench for discrete_filter_scheduler.
// Revision : 1.0
// ============================================================================
module tb_discrete_filter_scheduler;

    logic        clk = 1'b0;
    logic        I_RST = 1'b1;
    logic        audio_clk_en = 1'b0;
    logic [63:0] in_flat = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_coef = '0;
    logic        cfg_hp = 1'b0;
    logic [63:0] out_flat;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    discrete_filter_scheduler #(
        .NUM_CH(4), .SIGNAL_WIDTH(16), .COEF_WIDTH(16)
    ) dut (
        .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .in_flat(in_flat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef), .cfg_hp(cfg_hp),
        .out_flat(out_flat), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] outc(input int ch);
        return out_flat[ch*16 +: 16];
    endfunction

    task automatic set_in(input int ch, input logic [15:0] v);
        in_flat[ch*16 +: 16] = v;
    endtask

    task automatic cfg(input int ch, input logic [15:0] k, input logic hp);
        cfg_we = 1'b1; cfg_addr = 2'(ch); cfg_coef = k; cfg_hp = hp;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        I_RST = 1'b1; audio_clk_en = 1'b0; cfg_we = 1'b0; in_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        I_RST = 1'b0;
    endtask

    // Leaves the caller 1 time unit after the edge that samples the tick.
    task automatic pulse_tick();
        audio_clk_en = 1'b1;
        @(posedge clk); #1;
        audio_clk_en = 1'b0;
    endtask

    task automatic run_sample();
        pulse_tick();
        repeat (18) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        I_RST = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_flat !== 64'h0) begin n_errors++; $display("FAIL reset_out: got %h want 0", out_flat); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        I_RST = 1'b0;
    endtask

    task automatic test_lp_hp();
        logic [15:0] exp0 [3];
        logic [15:0] exp1 [3];
        int cyc, lat, nd;
        exp0 = '{16'h1000, 16'h1800, 16'h1C00};
        exp1 = '{16'h1000, 16'h0800, 16'h0400};
        do_reset();
        cfg(0, 16'h8000, 1'b0);
        cfg(1, 16'h8000, 1'b1);
        cfg(2, 16'h0000, 1'b0);
        cfg(3, 16'h0000, 1'b1);
        set_in(0, 16'd8192); set_in(1, 16'd8192); set_in(2, 16'd1000); set_in(3, 16'd1000);
        for (int s = 0; s < 3; s++) begin
            pulse_tick();
            cyc = 1; lat = 0; nd = 0;
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL lphp_busy_s%0d: got %b want 1", s, busy); end
            repeat (18) begin
                if (done === 1'b1) begin nd++; if (lat == 0) lat = cyc; end
                @(posedge clk); #1; cyc++;
            end
            n_checks++; if (lat != 13) begin n_errors++; $display("FAIL lphp_latency_s%0d: got %0d want 13", s, lat); end
            n_checks++; if (nd != 1) begin n_errors++; $display("FAIL lphp_done_count_s%0d: got %0d want 1", s, nd); end
            n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL lphp_idle_s%0d: got %b want 0", s, busy); end
            n_checks++; if (outc(0) !== exp0[s]) begin n_errors++; $display("FAIL lphp_out0_s%0d: got %h want %h", s, outc(0), exp0[s]); end
            n_checks++; if (outc(1) !== exp1[s]) begin n_errors++; $display("FAIL lphp_out1_s%0d: got %h want %h", s, outc(1), exp1[s]); end
            n_checks++; if (outc(2) !== 16'h0000) begin n_errors++; $display("FAIL lphp_out2_s%0d: got %h want 0000", s, outc(2)); end
            n_checks++; if (outc(3) !== 16'd1000) begin n_errors++; $display("FAIL lphp_out3_s%0d: got %h want %h", s, outc(3), 16'd1000); end
        end
    endtask

    task automatic test_overrun();
        int nd;
        do_reset();
        cfg(0, 16'h8000, 1'b0);
        set_in(0, 16'd8192);
        pulse_tick();
        @(posedge clk); #1;
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_before: got %b want 0", overrun); end
        pulse_tick();
        nd = 0;
        repeat (20) begin
            if (done === 1'b1) nd++;
            @(posedge clk); #1;
        end
        n_checks++; if (nd != 1) begin n_errors++; $display("FAIL ovr_done_count: got %0d want 1", nd); end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        n_checks++; if (outc(0) !== 16'h1000) begin n_errors++; $display("FAIL ovr_out0: got %h want 1000", outc(0)); end
        run_sample();
        n_checks++; if (outc(0) !== 16'h1800) begin n_errors++; $display("FAIL ovr_next_out0: got %h want 1800", outc(0)); end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_cfg_midsample();
        do_reset();
        cfg(0, 16'h8000, 1'b0);
        set_in(0, 16'd8192);
        pulse_tick();
        repeat (3) @(posedge clk);
        #1;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_coef = 16'hFFFF; cfg_hp = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        n_checks++; if (outc(0) !== 16'h1000) begin n_errors++; $display("FAIL cfg_old_k: got %h want 1000", outc(0)); end
        run_sample();
        n_checks++; if (outc(0) !== 16'h1FFF) begin n_errors++; $display("FAIL cfg_new_k: got %h want 1fff", outc(0)); end
        // Write coincident with the committing tick must wait one sample.
        set_in(0, 16'd0);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_coef = 16'h0000; cfg_hp = 1'b0;
        audio_clk_en = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; audio_clk_en = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        n_checks++; if (outc(0) !== 16'h0000) begin n_errors++; $display("FAIL cfg_coincident: got %h want 0000", outc(0)); end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_hp;
`ifdef DISCRETE_FILTER_SCHED_SATURATE_EN
        exp_hp = 16'h7FFF;
`else
        exp_hp = 16'hFFFF;
`endif
        do_reset();
        cfg(2, 16'hFFFF, 1'b0);
        set_in(2, 16'h8000);
        run_sample();
        n_checks++; if (outc(2) !== 16'h8000) begin n_errors++; $display("FAIL sat_preload: got %h want 8000", outc(2)); end
        cfg(2, 16'h0000, 1'b1);
        set_in(2, 16'h7FFF);
        run_sample();
        n_checks++; if (outc(2) !== exp_hp) begin n_errors++; $display("FAIL sat_hp_out2: got %h want %h", outc(2), exp_hp); end
    endtask

    task automatic test_reset_midsample();
        int nd;
        do_reset();
        cfg(0, 16'h8000, 1'b0);
        cfg(1, 16'h8000, 1'b0);
        set_in(0, 16'd8192); set_in(1, 16'd8192);
        pulse_tick();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (outc(0) !== 16'h1000) begin n_errors++; $display("FAIL rstmid_out0_pre: got %h want 1000", outc(0)); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
        @(posedge clk); #1;
        I_RST = 1'b1;
        @(posedge clk); #1;
        I_RST = 1'b0;
        n_checks++; if (out_flat !== 64'h0) begin n_errors++; $display("FAIL rstmid_out: got %h want 0", out_flat); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        nd = 0;
        repeat (20) begin
            if (done === 1'b1) nd++;
            @(posedge clk); #1;
        end
        n_checks++; if (nd != 0) begin n_errors++; $display("FAIL rstmid_late_done: got %0d want 0", nd); end
        n_checks++; if (out_flat !== 64'h0) begin n_errors++; $display("FAIL rstmid_out_hold: got %h want 0", out_flat); end
    endtask

    initial begin
        test_reset();
        test_lp_hp();
        test_overrun();
        test_cfg_midsample();
        test_saturate();
        test_reset_midsample();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
